// File: rtl/fleet_action_scheduler.sv
// Per-cycle action scheduler: gates each ship's fire/shield/cloak requests
// against energy, a fire cooldown and a shield duty limit, picks at most one
// firing ship per cycle round-robin, and registers the resulting grants.
module fleet_action_scheduler #(
    parameter int NUM_SHIPS      = 3,
    parameter int FIRE_COST      = 30,
    parameter int SHIELD_COST    = 25,
    parameter int CLOAK_COST     = 15,
    parameter int FIRE_COOLDOWN  = 6,
    parameter int SHIELD_MAX_RUN = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SHIPS-1:0]   req_fire,
    input  logic [NUM_SHIPS-1:0]   req_shield,
    input  logic [NUM_SHIPS-1:0]   req_cloak,
    input  logic [2*NUM_SHIPS-1:0] req_dir,
    input  logic [8*NUM_SHIPS-1:0] energy,
    input  logic [NUM_SHIPS-1:0]   destroyed,
    output logic [NUM_SHIPS-1:0]   attempt_fire,
    output logic [NUM_SHIPS-1:0]   attempt_shield,
    output logic [NUM_SHIPS-1:0]   attempt_cloak,
    output logic [2*NUM_SHIPS-1:0] fire_dir,
    output logic [7:0]             shots_fired
);

    localparam int PW = (NUM_SHIPS > 1) ? $clog2(NUM_SHIPS) : 1;
    localparam int CW = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;

    // Budget math is 9 bits wide so energy = 255 never wraps.
    localparam logic [8:0]    FIRE_C    = 9'(FIRE_COST);
    localparam logic [8:0]    SHIELD_C  = 9'(SHIELD_COST);
    localparam logic [8:0]    CLOAK_C   = 9'(CLOAK_COST);
    localparam logic [CW-1:0] CD_LOAD   = CW'(FIRE_COOLDOWN);
    localparam logic [CW-1:0] CD_ONE    = CW'(1);
    localparam logic [2:0]    RUN_MAX   = 3'(SHIELD_MAX_RUN);
    localparam logic [7:0]    SHOTS_MAX = 8'hFF;

    typedef enum logic [1:0] {
        READY    = 2'd0,
        COOLDOWN = 2'd1,
        DEAD     = 2'd2
    } ship_state_e;

    ship_state_e             state_q [NUM_SHIPS];
    ship_state_e             state_d [NUM_SHIPS];
    logic [CW-1:0]           cd_q    [NUM_SHIPS];
    logic [CW-1:0]           cd_d    [NUM_SHIPS];
    logic [2:0]              run_q   [NUM_SHIPS];
    logic [2:0]              run_d   [NUM_SHIPS];
    logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [NUM_SHIPS-1:0]    attempt_fire_q, attempt_fire_d;
    logic [NUM_SHIPS-1:0]    attempt_shield_q, attempt_shield_d;
    logic [NUM_SHIPS-1:0]    attempt_cloak_q, attempt_cloak_d;
    logic [2*NUM_SHIPS-1:0]  fire_dir_q, fire_dir_d;
    logic [7:0]              shots_q, shots_d;

    logic [8:0]              rem1 [NUM_SHIPS];
    logic [8:0]              rem2 [NUM_SHIPS];
    logic [NUM_SHIPS-1:0]    shield_ok, fire_elig, fire_gnt, cloak_ok;
    logic                    gnt_found;

    // Shield takes first claim on energy; fire eligibility sees what remains.
    always_comb begin
        shield_ok = '0;
        fire_elig = '0;
        for (int i = 0; i < NUM_SHIPS; i++) begin
            shield_ok[i] = req_shield[i] && ({1'b0, energy[8*i +: 8]} >= SHIELD_C) &&
                           (run_q[i] < RUN_MAX) && (state_q[i] != DEAD) && !destroyed[i];
            rem1[i]      = {1'b0, energy[8*i +: 8]} - (shield_ok[i] ? SHIELD_C : 9'd0);
            fire_elig[i] = req_fire[i] && (state_q[i] == READY) && !destroyed[i] &&
                           (rem1[i] >= FIRE_C);
        end
    end

    // Round-robin pick of one firing ship starting at rr_ptr.
    always_comb begin
        fire_gnt  = '0;
        gnt_found = 1'b0;
        rr_ptr_d  = rr_ptr_q;
        for (int off = 0; off < NUM_SHIPS; off++) begin
            if (!gnt_found && fire_elig[(int'(rr_ptr_q) + off) % NUM_SHIPS]) begin
                gnt_found = 1'b1;
                fire_gnt[(int'(rr_ptr_q) + off) % NUM_SHIPS] = 1'b1;
                rr_ptr_d = PW'((int'(rr_ptr_q) + off + 1) % NUM_SHIPS);
            end
        end
    end

    // Cloak uses energy left after shield and (only for the winner) fire.
    always_comb begin
        cloak_ok = '0;
        for (int i = 0; i < NUM_SHIPS; i++) begin
            rem2[i]     = rem1[i] - (fire_gnt[i] ? FIRE_C : 9'd0);
            cloak_ok[i] = req_cloak[i] && (rem2[i] >= CLOAK_C) &&
                          (state_q[i] != DEAD) && !destroyed[i];
        end
    end

    // Per-ship state machine, run counters, direction and shot count.
    always_comb begin
        fire_dir_d       = fire_dir_q;
        attempt_fire_d   = fire_gnt;
        attempt_shield_d = shield_ok;
        attempt_cloak_d  = cloak_ok;
        shots_d          = (gnt_found && (shots_q != SHOTS_MAX)) ? shots_q + 8'd1 : shots_q;
        for (int i = 0; i < NUM_SHIPS; i++) begin
            state_d[i] = state_q[i];
            cd_d[i]    = cd_q[i];
            run_d[i]   = shield_ok[i] ? run_q[i] + 3'd1 : 3'd0;
            if (fire_gnt[i]) begin
                fire_dir_d[2*i +: 2] = req_dir[2*i +: 2];
            end
            if (destroyed[i]) begin
                state_d[i] = DEAD;
                cd_d[i]    = '0;
                run_d[i]   = 3'd0;
            end else begin
                case (state_q[i])
                    READY: begin
                        if (fire_gnt[i]) begin
                            state_d[i] = COOLDOWN;
                            cd_d[i]    = CD_LOAD;
                        end
                    end
                    COOLDOWN: begin
                        if (cd_q[i] <= CD_ONE) begin
                            state_d[i] = READY;
                            cd_d[i]    = '0;
                        end else begin
                            cd_d[i] = cd_q[i] - CD_ONE;
                        end
                    end
                    default: begin
                        state_d[i] = DEAD;
                    end
                endcase
            end
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SHIPS; i++) begin
                state_q[i] <= READY;
                cd_q[i]    <= '0;
                run_q[i]   <= '0;
            end
            rr_ptr_q         <= '0;
            attempt_fire_q   <= '0;
            attempt_shield_q <= '0;
            attempt_cloak_q  <= '0;
            fire_dir_q       <= '0;
            shots_q          <= '0;
        end else begin
            for (int i = 0; i < NUM_SHIPS; i++) begin
                state_q[i] <= state_d[i];
                cd_q[i]    <= cd_d[i];
                run_q[i]   <= run_d[i];
            end
            rr_ptr_q         <= rr_ptr_d;
            attempt_fire_q   <= attempt_fire_d;
            attempt_shield_q <= attempt_shield_d;
            attempt_cloak_q  <= attempt_cloak_d;
            fire_dir_q       <= fire_dir_d;
            shots_q          <= shots_d;
        end
    end

    assign attempt_fire   = attempt_fire_q;
    assign attempt_shield = attempt_shield_q;
    assign attempt_cloak  = attempt_cloak_q;
    assign fire_dir       = fire_dir_q;
    assign shots_fired    = shots_q;

endmodule
